// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage bundle between the ID/EX register and the multiply/divide unit
interface ex_muldiv_if;
  logic [7:0]  ex_aluop;
  logic [31:0] ex_data1;
  logic [31:0] ex_data2;
  logic        flush;
  logic        stall_req;
  logic [31:0] result;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        busy;
  modport master(output ex_aluop, ex_data1, ex_data2, flush, input stall_req, result, hi_o, lo_o, busy);
  modport slave(input ex_aluop, ex_data1, ex_data2, flush, output stall_req, result, hi_o, lo_o, busy);
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: HI/LO owner with single-cycle multiply and 32-step restoring divider
module ex_muldiv #(
  parameter logic [7:0] OP_MULT  = 8'b00011000,
  parameter logic [7:0] OP_MULTU = 8'b00011001,
  parameter logic [7:0] OP_DIV   = 8'b00011010,
  parameter logic [7:0] OP_DIVU  = 8'b00011011,
  parameter logic [7:0] OP_MFHI  = 8'b00010000,
  parameter logic [7:0] OP_MTHI  = 8'b00010001,
  parameter logic [7:0] OP_MFLO  = 8'b00010010,
  parameter logic [7:0] OP_MTLO  = 8'b00010011
) (
  input logic       clk,
  input logic       rst,
  ex_muldiv_if.slave mdu
);
  typedef enum logic [1:0] {S_IDLE, S_ZERO, S_ON, S_END} state_t;
  state_t      r_state, w_next;
  logic [4:0]  r_cnt;
  logic [64:0] r_div;
  logic [31:0] r_dsr, r_hi, r_lo;
  logic        r_neg_q, r_neg_r, r_busy;
  logic        w_is_div, w_sgn, w_start;
  logic [31:0] w_a_abs, w_b_abs, w_quo, w_rem;
  logic [64:0] w_shift;
  logic [32:0] w_sub;
  logic [63:0] w_smul, w_umul;
  assign w_is_div = mdu.ex_aluop == OP_DIV || mdu.ex_aluop == OP_DIVU;
  assign w_sgn    = mdu.ex_aluop == OP_DIV;
  assign w_start  = r_state == S_IDLE && w_is_div && !mdu.flush;
  assign w_a_abs  = (w_sgn && mdu.ex_data1[31]) ? -mdu.ex_data1 : mdu.ex_data1;
  assign w_b_abs  = (w_sgn && mdu.ex_data2[31]) ? -mdu.ex_data2 : mdu.ex_data2;
  assign w_shift  = r_div << 1;
  assign w_sub    = w_shift[64:32] - {1'b0, r_dsr};
  assign w_quo    = r_neg_q ? -r_div[31:0] : r_div[31:0];
  assign w_rem    = r_neg_r ? -r_div[63:32] : r_div[63:32];
  // sign-extended operands make the low 64 bits of an unsigned product the signed product
  assign w_smul   = {{32{mdu.ex_data1[31]}}, mdu.ex_data1} * {{32{mdu.ex_data2[31]}}, mdu.ex_data2};
  assign w_umul   = {32'd0, mdu.ex_data1} * {32'd0, mdu.ex_data2};
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: w_next = w_start ? (mdu.ex_data2 == 32'd0 ? S_ZERO : S_ON) : S_IDLE;
      S_ZERO: w_next = mdu.flush ? S_IDLE : S_END;
      S_ON:   w_next = mdu.flush ? S_IDLE : (r_cnt == 5'd31 ? S_END : S_ON);
      S_END:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_cnt   <= 5'd0;
      r_div   <= 65'd0;
      r_dsr   <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_state <= w_next;
      r_busy  <= w_next != S_IDLE;
      if (w_start) begin
        r_cnt   <= 5'd0;
        r_div   <= mdu.ex_data2 == 32'd0 ? 65'd0 : {33'd0, w_a_abs};
        r_dsr   <= w_b_abs;
        r_neg_q <= w_sgn && (mdu.ex_data1[31] ^ mdu.ex_data2[31]);
        r_neg_r <= w_sgn && mdu.ex_data1[31];
      end else if (r_state == S_ON) begin
        r_cnt <= r_cnt + 5'd1;
        r_div <= w_sub[32] ? w_shift : {w_sub, w_shift[31:0] | 32'd1};
      end
      if (!mdu.flush) begin
        if (r_state == S_END)
          {r_hi, r_lo} <= {w_rem, w_quo};
        else if (r_state == S_IDLE) begin
          if (mdu.ex_aluop == OP_MULT) {r_hi, r_lo} <= w_smul;
          else if (mdu.ex_aluop == OP_MULTU) {r_hi, r_lo} <= w_umul;
          else if (mdu.ex_aluop == OP_MTHI) r_hi <= mdu.ex_data1;
          else if (mdu.ex_aluop == OP_MTLO) r_lo <= mdu.ex_data1;
        end
      end
    end
  end
  assign mdu.stall_req = !rst && (w_start || ((r_state == S_ZERO || r_state == S_ON) && !mdu.flush));
  assign mdu.result    = rst ? 32'd0 : mdu.ex_aluop == OP_MFHI ? r_hi : mdu.ex_aluop == OP_MFLO ? r_lo : 32'd0;
  assign mdu.hi_o      = r_hi;
  assign mdu.lo_o      = r_lo;
  assign mdu.busy      = r_busy;
endmodule
